// File: rtl/disp_bram_arbiter.sv
// Map-granular arbiter sharing one display-BRAM write port among N_REQ capture writers.
// Define DISP_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed lowest-index priority otherwise.
module disp_bram_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          done,
    input  logic [N_REQ-1:0]          we_in,
    input  logic [N_REQ*ADDR_W-1:0]   addr_in,
    input  logic [N_REQ*DATA_W-1:0]   wdata_in,
    output logic [N_REQ-1:0]          gnt,
    output logic [ADDR_W-1:0]         bram_addr,
    output logic [DATA_W-1:0]         bram_wdata,
    output logic                      bram_we,
    output logic [$clog2(N_REQ)-1:0]  owner_id,
    output logic                      busy,
    output logic                      timeout_err,
    output logic                      illegal_wr
);

    localparam int unsigned ID_W    = $clog2(N_REQ);
    localparam int unsigned WD_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned WD_LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] OWNED   = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic              busy_q, busy_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              tmo_q, tmo_d;
    logic              ill_q, ill_d;
    logic [WD_W-1:0]   wd_q, wd_d;

    logic [ID_W-1:0]   search_start;
    logic [ID_W-1:0]   winner;
    logic              own_we, own_done, own_req, wd_exp, ill_hit;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_wdata;

`ifdef DISP_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0]   rr_q, rr_d;
    assign search_start = rr_q;
`else
    assign search_start = '0;
`endif

    // First requester at or after start, wrapping; lowest offset wins.
    function automatic logic [ID_W-1:0] pick(input logic [N_REQ-1:0] r,
                                             input logic [ID_W-1:0]  start);
        logic [ID_W-1:0] w;
        int              idx;
        w = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            idx = (int'(start) + i) % int'(N_REQ);
            if (r[idx[ID_W-1:0]]) w = idx[ID_W-1:0];
        end
        return w;
    endfunction

    assign winner    = pick(req, search_start);
    // gnt_q is exactly the owner's one-hot while OWNED, so it masks owner-side inputs.
    assign own_we    = (state_q == OWNED) && |(we_in & gnt_q);
    assign own_done  = |(done & gnt_q);
    assign own_req   = |(req & gnt_q);
    assign own_addr  = addr_in[32'(owner_q)*ADDR_W +: ADDR_W];
    assign own_wdata = wdata_in[32'(owner_q)*DATA_W +: DATA_W];
    assign wd_exp    = (TIMEOUT_CYC != 0) && !own_we && (wd_q == WD_W'(WD_LAST));
    assign ill_hit   = |(we_in & ((state_q == OWNED) ? ~gnt_q : {N_REQ{1'b1}}));

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        busy_d  = busy_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        tmo_d   = 1'b0;
        ill_d   = ill_q | ill_hit;
        wd_d    = wd_q;
`ifdef DISP_ARB_ROUND_ROBIN_EN
        rr_d    = rr_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = OWNED;
                    gnt_d   = N_REQ'(1) << winner;
                    owner_d = winner;
                    busy_d  = 1'b1;
                    wd_d    = '0;
                end
            end
            OWNED: begin
                we_d = own_we;
                if (own_we) begin
                    addr_d  = own_addr;
                    wdata_d = own_wdata;
                end
                wd_d = own_we ? '0 : wd_q + WD_W'(1);
                if (own_done || !own_req || wd_exp) begin
                    state_d = RELEASE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    tmo_d   = wd_exp;
                    wd_d    = '0;
`ifdef DISP_ARB_ROUND_ROBIN_EN
                    rr_d    = ID_W'((32'(owner_q) + 1) % N_REQ);
`endif
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            tmo_q   <= 1'b0;
            ill_q   <= 1'b0;
            wd_q    <= '0;
`ifdef DISP_ARB_ROUND_ROBIN_EN
            rr_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            tmo_q   <= tmo_d;
            ill_q   <= ill_d;
            wd_q    <= wd_d;
`ifdef DISP_ARB_ROUND_ROBIN_EN
            rr_q    <= rr_d;
`endif
        end
    end

    assign gnt         = gnt_q;
    assign owner_id    = owner_q;
    assign busy        = busy_q;
    assign bram_we     = we_q;
    assign bram_addr   = addr_q;
    assign bram_wdata  = wdata_q;
    assign timeout_err = tmo_q;
    assign illegal_wr  = ill_q;

endmodule
